// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, trained by execute-stage resolution.
// Optional BP_STATS_EN macro adds saturating branch/mispredict counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ready,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic        update_taken,
    input  logic [31:0] update_target,
    input  logic        update_pred_taken,
    input  logic [31:0] update_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
`endif
);

    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [INDEX_BITS-1:0]   sweep_q;
    logic                    sweep_last;
    logic                    run;

    logic                    entry_valid  [ENTRIES];
    logic [TAG_BITS-1:0]     entry_tag    [ENTRIES];
    logic [31:0]             entry_target [ENTRIES];
    logic [1:0]              entry_ctr    [ENTRIES];

    logic [INDEX_BITS-1:0]   lk_idx;
    logic [TAG_BITS-1:0]     lk_tag;
    logic                    lk_hit;
    logic                    lk_taken;
    logic [31:0]             lk_target;

    logic [INDEX_BITS-1:0]   upd_idx;
    logic [TAG_BITS-1:0]     upd_tag;
    logic                    upd_hit;
    logic [1:0]              upd_ctr;
    logic [1:0]              upd_ctr_inc;
    logic [1:0]              upd_ctr_dec;
    logic                    upd_accept;
    logic                    upd_mis;
    logic [31:0]             upd_redirect;

    assign sweep_last = (sweep_q == {INDEX_BITS{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:    if (sweep_last) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        run   = (state_q == RUN);
        ready = run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_q <= '0;
        end else if (state_q == INIT) begin
            sweep_q <= sweep_q + 1'b1;
        end
    end

    always_comb begin
        lk_idx    = lookup_pc[INDEX_BITS+1:2];
        lk_tag    = lookup_pc[31:INDEX_BITS+2];
        lk_hit    = entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
        lk_taken  = lk_hit && entry_ctr[lk_idx][1];
        lk_target = lk_taken ? entry_target[lk_idx] : (lookup_pc + 32'd4);
    end

    always_comb begin
        upd_idx      = update_pc[INDEX_BITS+1:2];
        upd_tag      = update_pc[31:INDEX_BITS+2];
        upd_hit      = entry_valid[upd_idx] && (entry_tag[upd_idx] == upd_tag);
        upd_ctr      = entry_ctr[upd_idx];
        upd_ctr_inc  = (upd_ctr == 2'b11) ? 2'b11 : (upd_ctr + 2'd1);
        upd_ctr_dec  = (upd_ctr == 2'b00) ? 2'b00 : (upd_ctr - 2'd1);
        upd_accept   = run && update_valid;
        upd_mis      = (update_pred_taken != update_taken) ||
                       (update_taken && (update_pred_target != update_target));
        upd_redirect = update_taken ? update_target : (update_pc + 32'd4);
    end

    // Table storage has no reset: the INIT sweep is what clears it, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            entry_valid[sweep_q] <= 1'b0;
            entry_ctr[sweep_q]   <= 2'b01;
        end else if (update_valid) begin
            if (update_taken) begin
                if (upd_hit) begin
                    entry_ctr[upd_idx]    <= upd_ctr_inc;
                    entry_target[upd_idx] <= update_target;
                end else begin
                    entry_valid[upd_idx]  <= 1'b1;
                    entry_tag[upd_idx]    <= upd_tag;
                    entry_target[upd_idx] <= update_target;
                    entry_ctr[upd_idx]    <= 2'b10;
                end
            end else if (upd_hit) begin
                entry_ctr[upd_idx] <= upd_ctr_dec;
            end
        end
    end

    // Lookup reads the pre-update table, giving read-before-write on a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (run && lookup_valid) begin
            pred_valid  <= 1'b1;
            pred_taken  <= lk_taken;
            pred_target <= lk_target;
        end else begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else if (upd_accept && upd_mis) begin
            mispredict  <= 1'b1;
            redirect_pc <= upd_redirect;
        end else begin
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (upd_accept && (branch_count != 32'hFFFF_FFFF)) begin
                branch_count <= branch_count + 32'd1;
            end
            if (upd_accept && upd_mis && (mispredict_count != 32'hFFFF_FFFF)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed vectors push expected predictions and
// redirects; an independent monitor pops and compares whenever the DUT presents them.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_pred_taken;
    logic [31:0] update_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    typedef struct {
        logic        taken;
        logic [31:0] target;
    } pred_t;

    pred_t       pred_q[$];
    logic [31:0] redirect_q[$];
    int          checks;
    int          errors;
    int          exp_branch_count;
    int          exp_mis_count;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ready              (ready),
        .lookup_valid       (lookup_valid),
        .lookup_pc          (lookup_pc),
        .pred_valid         (pred_valid),
        .pred_taken         (pred_taken),
        .pred_target        (pred_target),
        .update_valid       (update_valid),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .mispredict         (mispredict),
        .redirect_pc        (redirect_pc)
`ifdef BP_STATS_EN
        ,
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one cycle of lookup/update at a negedge and records what the DUT owes us.
    task automatic applyStimulus(
        input logic lk_v, input logic [31:0] lk_pc, input logic exp_taken, input logic [31:0] exp_target,
        input logic up_v, input logic [31:0] up_pc, input logic up_t, input logic [31:0] up_tgt,
        input logic up_pt, input logic [31:0] up_ptgt, input logic exp_mis, input logic [31:0] exp_redirect);
        pred_t p;
        lookup_valid       = lk_v;
        lookup_pc          = lk_pc;
        update_valid       = up_v;
        update_pc          = up_pc;
        update_taken       = up_t;
        update_target      = up_tgt;
        update_pred_taken  = up_pt;
        update_pred_target = up_ptgt;
        if (lk_v) begin
            p.taken  = exp_taken;
            p.target = exp_target;
            pred_q.push_back(p);
        end
        if (up_v) begin
            exp_branch_count++;
            if (exp_mis) begin
                exp_mis_count++;
                redirect_q.push_back(exp_redirect);
            end
        end
        @(posedge clk);
        @(negedge clk);
        lookup_valid = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic doLookup(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_target);
        applyStimulus(1'b1, pc, exp_taken, exp_target, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic doUpdate(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                            input logic p_taken, input logic [31:0] p_target,
                            input logic exp_mis, input logic [31:0] exp_redirect);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, taken, target, p_taken, p_target, exp_mis, exp_redirect);
    endtask

    task automatic waitReady(input string name);
        int edges;
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ready) break;
        end
        checkOutput(name, edges, 32'd64);
    endtask

    task automatic checkStats(input string tag);
`ifdef BP_STATS_EN
        checkOutput({tag, "_branch_count"}, branch_count, exp_branch_count);
        checkOutput({tag, "_mispredict_count"}, mispredict_count, exp_mis_count);
`endif
    endtask

    // Monitor: compares every presented prediction and redirect against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (pred_valid) begin
                if (pred_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pred: got pred_valid=1 taken=%0b target=0x%08h, expected none",
                             pred_taken, pred_target);
                end else begin
                    pred_t p;
                    p = pred_q.pop_front();
                    checkOutput("pred_taken", {31'b0, pred_taken}, {31'b0, p.taken});
                    checkOutput("pred_target", pred_target, p.target);
                end
            end
            if (mispredict) begin
                if (redirect_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_mispredict: got redirect_pc=0x%08h, expected none", redirect_pc);
                end else begin
                    checkOutput("redirect_pc", redirect_pc, redirect_q.pop_front());
                end
            end
        end
    end

    initial begin
        checks             = 0;
        errors             = 0;
        exp_branch_count   = 0;
        exp_mis_count      = 0;
        rst_n              = 1'b0;
        lookup_valid       = 1'b0;
        lookup_pc          = '0;
        update_valid       = 1'b0;
        update_pc          = '0;
        update_taken       = 1'b0;
        update_target      = '0;
        update_pred_taken  = 1'b0;
        update_pred_target = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", {31'b0, ready}, 32'd0);
        checkOutput("reset_pred_valid", {31'b0, pred_valid}, 32'd0);
        checkOutput("reset_pred_taken", {31'b0, pred_taken}, 32'd0);
        checkOutput("reset_pred_target", pred_target, 32'd0);
        checkOutput("reset_mispredict", {31'b0, mispredict}, 32'd0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
        checkStats("reset");

        // Activity during INIT must be ignored: no predictions, no redirects, no training.
        rst_n              = 1'b1;
        lookup_valid       = 1'b1;
        lookup_pc          = 32'h100;
        update_valid       = 1'b1;
        update_pc          = 32'h100;
        update_taken       = 1'b1;
        update_target      = 32'h80;
        update_pred_taken  = 1'b0;
        update_pred_target = 32'h104;
        waitReady("init_cycles");
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        checkStats("after_init");

        doLookup(32'h100, 1'b0, 32'h104);
        doUpdate(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        doLookup(32'h100, 1'b1, 32'h80);

        // Counter walk from weak taken: saturate, then decay back to weak not-taken.
        doUpdate(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
        doUpdate(32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0, 32'h0);
        doUpdate(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
        doLookup(32'h100, 1'b1, 32'h80);
        doUpdate(32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h104);
        doLookup(32'h100, 1'b0, 32'h104);
        doUpdate(32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1, 32'h80);
        doLookup(32'h100, 1'b1, 32'h80);

        // Aliasing at index 0.
        doLookup(32'h200, 1'b0, 32'h204);
        doUpdate(32'h200, 1'b0, 32'h0, 1'b0, 32'h204, 1'b0, 32'h0);
        doLookup(32'h100, 1'b1, 32'h80);
        doUpdate(32'h200, 1'b1, 32'h400, 1'b0, 32'h204, 1'b1, 32'h400);
        doLookup(32'h100, 1'b0, 32'h104);
        doLookup(32'h200, 1'b1, 32'h400);
        checkStats("after_alias");

        // Same-cycle lookup and update: read-before-write, then visible next cycle.
        applyStimulus(1'b1, 32'h300, 1'b0, 32'h304,
                      1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304, 1'b1, 32'h500);
        doLookup(32'h300, 1'b1, 32'h500);
        checkStats("after_same_cycle");

        // Target mismatch with correct direction still redirects.
        doUpdate(32'h300, 1'b1, 32'h600, 1'b1, 32'h500, 1'b1, 32'h600);
        doLookup(32'h300, 1'b1, 32'h600);
        doLookup(32'h302, 1'b1, 32'h600);

        // pc+4 wraps at the top of the address space.
        doUpdate(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1, 32'h0000_0000);
        checkStats("after_wrap");

        // Asynchronous reset mid-operation clears outputs at once and reruns INIT.
        lookup_valid       = 1'b1;
        lookup_pc          = 32'hFFFF_FFFC;
        update_valid       = 1'b1;
        update_pc          = 32'h300;
        update_taken       = 1'b0;
        update_target      = 32'h0;
        update_pred_taken  = 1'b1;
        update_pred_target = 32'h600;
        pred_q.push_back('{taken: 1'b0, target: 32'h0});
        redirect_q.push_back(32'h304);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        lookup_valid     = 1'b0;
        update_valid     = 1'b0;
        exp_branch_count = 0;
        exp_mis_count    = 0;
        checkOutput("midreset_pred_valid", {31'b0, pred_valid}, 32'd0);
        checkOutput("midreset_mispredict", {31'b0, mispredict}, 32'd0);
        checkOutput("midreset_redirect_pc", redirect_pc, 32'd0);
        checkOutput("midreset_ready", {31'b0, ready}, 32'd0);
        checkStats("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        waitReady("reinit_cycles");
        doLookup(32'h300, 1'b0, 32'h304);

        repeat (3) @(negedge clk);
        checkOutput("pred_queue_drained", pred_q.size(), 32'd0);
        checkOutput("redirect_queue_drained", redirect_q.size(), 32'd0);
        checkStats("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Front-end branch predictor: a direct-mapped branch target buffer with 2-bit saturating counters. It predicts taken/not-taken and the next PC at fetch. It is trained by the execute-stage branch resolution result (taken flag and target). It compares that resolution against the original prediction and raises a registered mispredict/redirect to flush fetch.

## Interface
- INDEX_BITS, 6, log2 of entry count; index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ready  out  1  table initialised; lookups/updates accepted
- lookup_valid  in  1  fetch lookup request
- lookup_pc  in  32  fetch PC
- pred_valid  out  1  prediction present
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- update_valid  in  1  resolved branch present
- update_pc  in  32  PC of resolved branch
- update_taken  in  1  actual outcome (execute-stage take_branch)
- update_target  in  32  actual branch target
- update_pred_taken  in  1  prediction carried down the pipe
- update_pred_target  in  32  predicted target carried down the pipe
- mispredict  out  1  registered flush request
- redirect_pc  out  32  correct next PC when mispredict=1
- branch_count, mispredict_count  out  32 each  only with BP_STATS_EN

## Operation
- Each entry holds valid, tag, 32-bit target and a 2-bit counter. States: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- FSM states:
  - INIT: a sweep counter walks index 0..2^INDEX_BITS-1, one entry per cycle, writing valid=0 and counter=01. After the last index the FSM goes to RUN.
  - RUN: normal operation. ready=1 only in RUN.
- Lookup (RUN, lookup_valid):
  - hit = valid && tag match.
  - pred_taken = hit && counter[1].
  - pred_target = stored target if pred_taken, else lookup_pc+4.
- Update (RUN, update_valid):
  - Taken, hit: counter saturating +1, target overwritten.
  - Taken, miss: allocate the entry (overwriting any alias). Set valid=1, new tag, target=update_target, counter=10.
  - Not taken, hit: counter saturating −1.
  - Not taken, miss: no change; no allocation.
- Mispredict:
  - mispredict = update_valid && (update_pred_taken≠update_taken || (update_taken && update_pred_target≠update_target)).
  - redirect_pc = update_taken ? update_target : update_pc+4.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFFFFFC → 0x00000000). pc[1:0] is ignored for index and tag.

## Timing
- Reset values:
  - ready, pred_valid, pred_taken, mispredict: 0.
  - pred_target, redirect_pc: 0.
  - FSM = INIT, sweep counter 0.
  - Stats counters 0.
- INIT lasts exactly 2^INDEX_BITS cycles after rst_n deasserts. ready rises on the following edge.
- Lookup latency 1:
  - pred_* are registered on the edge after lookup_valid.
  - pred_valid=0 in any cycle following no lookup.
  - Back-to-back lookups are sustained every cycle.
- Update is written on the update_valid edge. mispredict/redirect_pc are registered on the same edge and are one-cycle pulses.
- Lookup and update in the same cycle, same index: the lookup returns pre-update state (read-before-write). A lookup in the next cycle sees the update.
- Lookups and updates during INIT are ignored:
  - pred_valid stays 0.
  - Table unchanged.
  - mispredict stays 0.
- rst_n asserted mid-operation: all outputs return to reset values immediately and the FSM restarts INIT.

## Configuration
- BP_STATS_EN:
  - Defined: adds branch_count (+1 per update_valid accepted in RUN) and mispredict_count (+1 per mispredict). Both saturate at 0xFFFFFFFF and are reset to 0.
  - Undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release with INDEX_BITS=6 → ready=0 for 64 cycles, then 1; lookup 0x100 during INIT → pred_valid=0.
- Cold lookup 0x100 → next cycle pred_valid=1, pred_taken=0, pred_target=0x104.
- Update pc=0x100 taken, target=0x80, pred_taken=0 → mispredict=1, redirect_pc=0x80. Then lookup 0x100 → pred_taken=1, pred_target=0x80.
- Counter walk at 0x100, starting from weak T:
  - Two taken updates → 11 (saturated).
  - One not-taken → 10, lookup predicts taken.
  - Second not-taken → 01, lookup predicts not-taken with target 0x104.
- Alias: with 0x100 trained taken, lookup 0x200 (same index 0) → pred_taken=0, target 0x204. A not-taken update at 0x200 leaves the 0x100 entry intact. A taken update at 0x200 replaces it, and lookup 0x100 then misses.
- Same-cycle lookup and taken update at cold 0x300 → lookup returns not-taken; lookup next cycle returns taken. With BP_STATS_EN: branch_count and mispredict_count each increment by 1.
